ula: RTL and testbench

//   16-bit two-function arithmetic unit: adds (sel=0) or subtracts (sel=1) operands A and B.

---
 rtl/ula.sv | 88 ++++++++
 tb/tb_ula.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/ula.sv
`default_nettype none
// ============================================================================
// Module   : ula
// Purpose  : Two-function arithmetic unit (A+B or A-B) with registered result
//            and status flags. Acts as one pipeline stage: inputs sampled on
//            a rising clk edge appear on the outputs right after that edge.
// Ports    : clk   - system clock, rising-edge active
//            rst   - synchronous active-high reset
//            A, B  - operands (unsigned or two's-complement)
//            sel   - 0 = A+B, 1 = A-B
//            saida - registered result
//            carry - add: carry-out, sub: borrow (A < B unsigned)
//            ovf   - signed overflow of the selected operation
//            zero  - result equals zero
//            neg   - result MSB
// Revision : 1.0 - initial release
// ============================================================================
module ula #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sel,
  output logic [WIDTH-1:0] saida,
  output logic             carry,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam logic [WIDTH:0] ONE_EXT = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH:0]   add_ext;
  logic [WIDTH:0]   sub_ext;
  logic [WIDTH-1:0] result_next;
  logic             carry_next;
  logic             ovf_next;

  logic [WIDTH-1:0] result_q;
  logic             carry_q;
  logic             ovf_q;

  // Subtraction is A + ~B + 1; its top bit is the "no borrow" indicator, so
  // the borrow flag is its inverse.
  assign add_ext = {1'b0, A} + {1'b0, B};
  assign sub_ext = {1'b0, A} + {1'b0, ~B} + ONE_EXT;

  always_comb begin
    result_next = add_ext[WIDTH-1:0];
    carry_next  = add_ext[WIDTH];
    ovf_next    = 1'b0;
    if (sel) begin
      result_next = sub_ext[WIDTH-1:0];
      carry_next  = ~sub_ext[WIDTH];
      // Signs differ and the result's sign departs from A's.
      ovf_next    = (A[WIDTH-1] != B[WIDTH-1]) &&
                    (result_next[WIDTH-1] != A[WIDTH-1]);
    end else begin
      // Signs equal and the result's sign departs from theirs.
      ovf_next    = (A[WIDTH-1] == B[WIDTH-1]) &&
                    (result_next[WIDTH-1] != A[WIDTH-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      result_q <= result_next;
      carry_q  <= carry_next;
      ovf_q    <= ovf_next;
    end
  end

  // zero/neg are pure functions of the registered result, so after reset
  // they read zero=1, neg=0 without needing their own flops.
  assign saida = result_q;
  assign carry = carry_q;
  assign ovf   = ovf_q;
  assign zero  = (result_q == '0);
  assign neg   = result_q[WIDTH-1];

endmodule
`default_nettype wire

// File: tb/tb_ula.sv
`default_nettype none
// ============================================================================
// Module   : tb_ula
// Purpose  : Self-checking bench for ula. Directed cases plus randomized
//            operations compared against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ula;

  localparam int WIDTH = 16;
  localparam int MOD   = 1 << WIDTH;
  localparam int HALF  = 1 << (WIDTH - 1);

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             sel;
  logic [WIDTH-1:0] saida;
  logic             carry;
  logic             ovf;
  logic             zero;
  logic             neg;

  int checks;
  int errors;

  ula #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .A     (A),
    .B     (B),
    .sel   (sel),
    .saida (saida),
    .carry (carry),
    .ovf   (ovf),
    .zero  (zero),
    .neg   (neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  task automatic model(input int a, input int b, input bit s, input bit r,
                       output int res, output int c, output int o,
                       output int z, output int n);
    int full;
    int sa;
    int sb;
    int sfull;
    sa = (a >= HALF) ? a - MOD : a;
    sb = (b >= HALF) ? b - MOD : b;
    if (r) begin
      res = 0; c = 0; o = 0;
    end else if (!s) begin
      full  = a + b;
      res   = full % MOD;
      c     = (full >= MOD) ? 1 : 0;
      sfull = sa + sb;
      o     = (sfull >= HALF || sfull < -HALF) ? 1 : 0;
    end else begin
      full  = a - b;
      res   = (full < 0) ? full + MOD : full;
      c     = (a < b) ? 1 : 0;
      sfull = sa - sb;
      o     = (sfull >= HALF || sfull < -HALF) ? 1 : 0;
    end
    z = (res == 0) ? 1 : 0;
    n = (res >= HALF) ? 1 : 0;
  endtask

  task automatic apply(input int a, input int b, input bit s, input bit r,
                       input string tag);
    int res, c, o, z, n;
    @(negedge clk);
    A   = a[WIDTH-1:0];
    B   = b[WIDTH-1:0];
    sel = s;
    rst = r;
    model(a, b, s, r, res, c, o, z, n);
    @(posedge clk);
    #1;
    check({tag, ".saida"}, int'(saida), res);
    check({tag, ".carry"}, int'(carry), c);
    check({tag, ".ovf"},   int'(ovf),   o);
    check({tag, ".zero"},  int'(zero),  z);
    check({tag, ".neg"},   int'(neg),   n);
  endtask

  initial begin
    int a, b;
    bit s;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    A   = '0;
    B   = '0;
    sel = 1'b0;

    // Reset: operands nonzero to show rst wins.
    apply(16'h1111, 16'h2222, 1'b0, 1'b1, "reset");

    apply(16'h0002, 16'h0003, 1'b0, 1'b0, "add_2_3");
    apply(16'h0002, 16'h0003, 1'b1, 1'b0, "sub_2_3");
    apply(16'h0004, 16'h0002, 1'b0, 1'b0, "add_4_2");
    apply(16'h0004, 16'h0002, 1'b1, 1'b0, "sub_4_2");
    apply(16'hFFFF, 16'h0001, 1'b0, 1'b0, "add_wrap");
    apply(16'h7FFF, 16'h0001, 1'b0, 1'b0, "add_ovf");
    apply(16'h8000, 16'h8000, 1'b0, 1'b0, "add_negovf");
    apply(16'h8000, 16'h0001, 1'b1, 1'b0, "sub_ovf");
    apply(16'h7FFF, 16'hFFFF, 1'b1, 1'b0, "sub_ovf2");
    apply(16'h1234, 16'h1234, 1'b1, 1'b0, "sub_zero");
    apply(16'h0000, 16'hFFFF, 1'b1, 1'b0, "sub_borrow");

    // Reset mid-stream, then release with the same operands.
    apply(16'h0004, 16'h0002, 1'b0, 1'b1, "mid_rst");
    apply(16'h0004, 16'h0002, 1'b0, 1'b0, "after_rst");

    // Outputs hold when inputs change between edges.
    @(negedge clk);
    A = 16'hAAAA;
    B = 16'h5555;
    sel = 1'b1;
    #2;
    check("hold.saida", int'(saida), 16'h0006);

    for (int i = 0; i < 300; i++) begin
      a = int'($urandom_range(MOD - 1, 0));
      b = int'($urandom_range(MOD - 1, 0));
      s = bit'($urandom_range(1, 0));
      if (i % 17 == 0) b = a;
      if (i % 23 == 0) a = HALF - 1 + (i % 3);
      apply(a, b, s, 1'b0, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
